// File: rtl/data_mem_responder.sv
// Multi-port data memory responder: round-robin arbitration among consumer ports,
// one access at a time through a single storage port with a fixed grant-to-ready latency.
module data_mem_responder #(
    parameter int DATA_MEM_ADDR_BITS = 8,
    parameter int DATA_MEM_DATA_BITS = 8,
    parameter int THREADS_PER_BLOCK  = 4,
    parameter int LATENCY            = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [THREADS_PER_BLOCK-1:0]  mem_read_valid,
    input  logic [DATA_MEM_ADDR_BITS-1:0] mem_read_address [THREADS_PER_BLOCK],
    output logic [THREADS_PER_BLOCK-1:0]  mem_read_ready,
    output logic [DATA_MEM_DATA_BITS-1:0] mem_read_data [THREADS_PER_BLOCK],
    input  logic [THREADS_PER_BLOCK-1:0]  mem_write_valid,
    input  logic [DATA_MEM_ADDR_BITS-1:0] mem_write_address [THREADS_PER_BLOCK],
    input  logic [DATA_MEM_DATA_BITS-1:0] mem_write_data [THREADS_PER_BLOCK],
    output logic [THREADS_PER_BLOCK-1:0]  mem_write_ready
);
    localparam int PW    = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1;
    localparam int DEPTH = 1 << DATA_MEM_ADDR_BITS;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]                    state_reg;
    logic [3:0]                    cnt_reg;
    logic [PW-1:0]                 rr_ptr_reg;
    logic [PW-1:0]                 grant_reg;
    logic                          is_write_reg;
    logic [DATA_MEM_ADDR_BITS-1:0] addr_reg;
    logic [DATA_MEM_DATA_BITS-1:0] wdata_reg;

    logic [DATA_MEM_DATA_BITS-1:0] mem [DEPTH];

    logic [THREADS_PER_BLOCK-1:0]  req;
    logic                          any_req;
    logic [PW-1:0]                 pick;
    logic [PW-1:0]                 rr_ptr_next;
    logic                          granted_valid;
    logic                          access;

    assign req = mem_read_valid | mem_write_valid;

    // First requesting port at or after the round-robin pointer, wrapping around.
    always_comb begin
        int idx;
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int k = 0; k < THREADS_PER_BLOCK; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= THREADS_PER_BLOCK) begin
                idx = idx - THREADS_PER_BLOCK;
            end
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = PW'(idx);
            end
        end
    end

    assign rr_ptr_next   = PW'((int'(pick) + 1) % THREADS_PER_BLOCK);
    assign granted_valid = is_write_reg ? mem_write_valid[grant_reg] : mem_read_valid[grant_reg];
    assign access        = (state_reg == BUSY) && (cnt_reg == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            rr_ptr_reg      <= '0;
            grant_reg       <= '0;
            is_write_reg    <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
                mem_read_data[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        // A port asking for both is served as a write; its read waits.
                        grant_reg    <= pick;
                        is_write_reg <= mem_write_valid[pick];
                        addr_reg     <= mem_write_valid[pick] ? mem_write_address[pick]
                                                              : mem_read_address[pick];
                        wdata_reg    <= mem_write_data[pick];
                        cnt_reg      <= CNT_LOAD;
                        rr_ptr_reg   <= rr_ptr_next;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        if (is_write_reg) begin
                            mem_write_ready[grant_reg] <= 1'b1;
                        end else begin
                            mem_read_ready[grant_reg] <= 1'b1;
                            mem_read_data[grant_reg]  <= mem[addr_reg];
                        end
                        state_reg <= RESPOND;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESPOND: begin
                    if (!granted_valid) begin
                        mem_read_ready  <= '0;
                        mem_write_ready <= '0;
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Storage is never reset; a reset during BUSY forces IDLE so the write is dropped.
    always_ff @(posedge clk) begin
        if (access && is_write_reg) begin
            mem[addr_reg] <= wdata_reg;
        end
    end
endmodule
